// File: rtl/controller_if.sv
// UART-side handshake bundle for the memory controller.
// master: UART driver side; slave: controller side.
interface controller_if;
    logic       received;
    logic [7:0] rx_byte;
    logic       is_transmitting;
    logic       transmit;
    logic [7:0] tx_byte;

    modport master (
        output received,
        output rx_byte,
        output is_transmitting,
        input  transmit,
        input  tx_byte
    );

    modport slave (
        input  received,
        input  rx_byte,
        input  is_transmitting,
        output transmit,
        output tx_byte
    );
endinterface

// File: rtl/controller.sv
// UART command controller over an internal byte memory.
// Frames: command, length N, address hi, address lo, then N+1 data bytes
// (WRITE), N+1 transmitted bytes (READ) or an N+1 byte fill (DRAW).
// Optional feature macro: CONTROLLER_DRAW_EN enables the DRAW command.
`define COMMAND_WRITE 8'h40
`define COMMAND_READ  8'h80
`define COMMAND_DRAW  8'hC0

module controller #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic         clock,
    input  logic         reset,
    controller_if.slave  bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [1:0] FIELD_WRITE = 2'(`COMMAND_WRITE >> 6);
    localparam logic [1:0] FIELD_READ  = 2'(`COMMAND_READ >> 6);
`ifdef CONTROLLER_DRAW_EN
    localparam logic [1:0] FIELD_DRAW  = 2'(`COMMAND_DRAW >> 6);
`endif

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN,
        S_ADDR_HI,
        S_ADDR_LO,
        S_WR_DATA,
        S_RD_FETCH,
        S_RD_SEND,
        S_RD_WAIT
`ifdef CONTROLLER_DRAW_EN
        , S_DRAW_FILL
`endif
    } state_t;

    state_t                  state;
    logic [1:0]              cmd_q;
    logic [7:0]              cnt_q;
    logic [7:0]              addr_hi_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    transmit_q;
    logic [7:0]              tx_byte_q;
    logic [7:0]              rd_data_q;
`ifdef CONTROLLER_DRAW_EN
    logic [5:0]              param_q;
`endif

    logic [7:0]              mem [DEPTH];

    logic                    mem_we_c;
    logic [7:0]              mem_wd_c;
    logic [15:0]             addr_full_c;

    assign bus.transmit = transmit_q;
    assign bus.tx_byte  = tx_byte_q;
    assign addr_full_c  = {addr_hi_q, bus.rx_byte};

    // Memory write strobe/data: WRITE data bytes and DRAW fill cycles.
    always_comb begin
        mem_we_c = 1'b0;
        mem_wd_c = bus.rx_byte;
        if (!reset) begin
            case (state)
                S_WR_DATA:   mem_we_c = bus.received;
`ifdef CONTROLLER_DRAW_EN
                S_DRAW_FILL: begin
                    mem_we_c = 1'b1;
                    mem_wd_c = {2'b00, param_q};
                end
`endif
                default:     mem_we_c = 1'b0;
            endcase
        end
    end

    // Byte memory with one-cycle registered read; never cleared by reset.
    always_ff @(posedge clock) begin
        if (mem_we_c) begin
            mem[addr_q] <= mem_wd_c;
        end
        rd_data_q <= mem[addr_q];
    end

    // Frame parser, transfer sequencing and registered UART outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            cmd_q      <= 2'b00;
            cnt_q      <= 8'h00;
            addr_hi_q  <= 8'h00;
            addr_q     <= '0;
            transmit_q <= 1'b0;
            tx_byte_q  <= 8'h00;
`ifdef CONTROLLER_DRAW_EN
            param_q    <= 6'h00;
`endif
        end else begin
            transmit_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.received) begin
                        cmd_q <= bus.rx_byte[7:6];
                        case (bus.rx_byte[7:6])
                            FIELD_WRITE: state <= S_LEN;
                            FIELD_READ:  state <= S_LEN;
`ifdef CONTROLLER_DRAW_EN
                            FIELD_DRAW: begin
                                param_q <= bus.rx_byte[5:0];
                                state   <= S_LEN;
                            end
`endif
                            default:     state <= S_IDLE;
                        endcase
                    end
                end
                S_LEN: begin
                    if (bus.received) begin
                        cnt_q <= bus.rx_byte;
                        state <= S_ADDR_HI;
                    end
                end
                S_ADDR_HI: begin
                    if (bus.received) begin
                        addr_hi_q <= bus.rx_byte;
                        state     <= S_ADDR_LO;
                    end
                end
                S_ADDR_LO: begin
                    if (bus.received) begin
                        addr_q <= ADDR_WIDTH'(addr_full_c);
                        case (cmd_q)
                            FIELD_WRITE: state <= S_WR_DATA;
                            FIELD_READ:  state <= S_RD_FETCH;
`ifdef CONTROLLER_DRAW_EN
                            FIELD_DRAW:  state <= S_DRAW_FILL;
`endif
                            default:     state <= S_IDLE;
                        endcase
                    end
                end
                S_WR_DATA: begin
                    if (bus.received) begin
                        addr_q <= addr_q + ADDR_WIDTH'(1);
                        if (cnt_q == 8'h00) begin
                            state <= S_IDLE;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                end
                S_RD_FETCH: begin
                    state <= S_RD_SEND;
                end
                S_RD_SEND: begin
                    if (!bus.is_transmitting) begin
                        transmit_q <= 1'b1;
                        tx_byte_q  <= rd_data_q;
                        state      <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    addr_q <= addr_q + ADDR_WIDTH'(1);
                    if (cnt_q == 8'h00) begin
                        state <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                        state <= S_RD_FETCH;
                    end
                end
`ifdef CONTROLLER_DRAW_EN
                S_DRAW_FILL: begin
                    addr_q <= addr_q + ADDR_WIDTH'(1);
                    if (cnt_q == 8'h00) begin
                        state <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_controller.sv
// Directed bench for controller: UART byte frames in, transmit pulses captured
// by a small UART model that also raises is_transmitting after each pulse.
module tb_controller;

    logic clock = 1'b0;
    logic reset;

    controller_if bus ();

    controller #(.ADDR_WIDTH(12)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    int busy_len = 1;
    int busy_cnt = 0;
    int viol     = 0;
    logic prev_tx = 1'b0;

    logic [7:0] cap[$];
    int         cap_cyc[$];

    assign bus.is_transmitting = (busy_cnt != 0);

    // UART model: capture pulses, hold busy, flag protocol violations.
    always @(posedge clock) begin
        cycle   <= cycle + 1;
        prev_tx <= bus.transmit;
        if (bus.transmit === 1'b1) begin
            cap.push_back(bus.tx_byte);
            cap_cyc.push_back(cycle);
            if (prev_tx || bus.is_transmitting) viol <= viol + 1;
            busy_cnt <= busy_len;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; consecutive calls produce back-to-back strobes.
    task automatic send_seq(input logic [7:0] b[$]);
        foreach (b[i]) begin
            bus.received = 1'b1;
            bus.rx_byte  = b[i];
            @(negedge clock);
            bus.received = 1'b0;
        end
    endtask

    task automatic wait_pulses(input string tag, input int n);
        int k;
        k = 0;
        while (cap.size() < n && k < 3000) begin
            @(negedge clock);
            k++;
        end
        repeat (10) @(negedge clock);
        check({tag, "_count"}, 32'(cap.size()), 32'(n));
    endtask

    task automatic check_bytes(input string tag, input logic [7:0] exp[$]);
        foreach (exp[i]) begin
            check($sformatf("%s_b%0d", tag, i),
                  (i < cap.size()) ? 32'(cap[i]) : 32'hDEAD_BEEF, 32'(exp[i]));
        end
    endtask

    function automatic logic [31:0] gap(input int i);
        return (cap_cyc.size() > i + 1) ? 32'(cap_cyc[i+1] - cap_cyc[i]) : 32'hFFFF_FFFF;
    endfunction

    task automatic clear_cap();
        cap.delete();
        cap_cyc.delete();
    endtask

    logic [7:0] big[$];
    logic [7:0] big_exp[$];

    initial begin
        bus.received = 1'b0;
        bus.rx_byte  = 8'h00;
        reset        = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("reset_transmit", 32'(bus.transmit), 32'h0);
        check("reset_tx_byte",  32'(bus.tx_byte),  32'h00);

        // Basic write then read back three bytes.
        send_seq('{8'h40, 8'h02, 8'h0E, 8'hCD, 8'h42, 8'h43, 8'h44});
        clear_cap();
        send_seq('{8'h80, 8'h02, 8'h0E, 8'hCD});
        wait_pulses("rd0ecd", 3);
        check_bytes("rd0ecd", '{8'h42, 8'h43, 8'h44});
        check("rd0ecd_gap0", gap(0), 32'd3);
        check("rd0ecd_gap1", gap(1), 32'd3);
        check("hold_tx_byte", 32'(bus.tx_byte), 32'h44);
        check("hold_transmit", 32'(bus.transmit), 32'h0);

        // Reset mid-frame aborts it; memory untouched, outputs cleared.
        send_seq('{8'h40, 8'h02, 8'h0E});
        reset = 1'b1;
        bus.received = 1'b1;
        bus.rx_byte  = 8'hCD;
        @(negedge clock);
        bus.received = 1'b0;
        reset = 1'b0;
        check("rst_mid_transmit", 32'(bus.transmit), 32'h0);
        check("rst_mid_tx_byte",  32'(bus.tx_byte),  32'h00);
        clear_cap();
        send_seq('{8'h80, 8'h02, 8'h0E, 8'hCD});
        wait_pulses("rst_rd", 3);
        check_bytes("rst_rd", '{8'h42, 8'h43, 8'h44});

        // Busy UART: each next pulse waits for is_transmitting to drop.
        send_seq('{8'h40, 8'h02, 8'h0A, 8'h10, 8'h44, 8'h45, 8'h46});
        busy_len = 5;
        clear_cap();
        send_seq('{8'h80, 8'h02, 8'h0A, 8'h10});
        wait_pulses("busy", 3);
        check_bytes("busy", '{8'h44, 8'h45, 8'h46});
        check("busy_gap0", gap(0), 32'd7);
        check("busy_gap1", gap(1), 32'd7);
        busy_len = 1;

        // Address wrap at the 12-bit boundary, with a NOP byte in IDLE.
        send_seq('{8'h40, 8'h00, 8'h0F, 8'hFF, 8'hAA});
        send_seq('{8'h40, 8'h00, 8'h00, 8'h00, 8'hBB});
        send_seq('{8'h15});
        clear_cap();
        send_seq('{8'h80, 8'h01, 8'hFF, 8'hFF});
        wait_pulses("wrap", 2);
        check_bytes("wrap", '{8'hAA, 8'hBB});

        // Bytes arriving during a READ are dropped.
        clear_cap();
        send_seq('{8'h80, 8'h02, 8'h0A, 8'h10, 8'h40, 8'h00, 8'h00, 8'h00});
        wait_pulses("drop", 3);
        check_bytes("drop", '{8'h44, 8'h45, 8'h46});
        clear_cap();
        send_seq('{8'h80, 8'h00, 8'h0A, 8'h10});
        wait_pulses("drop_idle", 1);
        check_bytes("drop_idle", '{8'h44});

        // Full 256-byte transfer crossing the wrap point.
        big.delete();
        big_exp.delete();
        big.push_back(8'h40);
        big.push_back(8'hFF);
        big.push_back(8'h0F);
        big.push_back(8'h80);
        for (int i = 0; i < 256; i++) begin
            big.push_back(8'(i) ^ 8'h5A);
            big_exp.push_back(8'(i) ^ 8'h5A);
        end
        send_seq(big);
        clear_cap();
        send_seq('{8'h80, 8'hFF, 8'h0F, 8'h80});
        wait_pulses("full", 256);
        check_bytes("full", big_exp);

        // DRAW fill (or NOP when the feature is compiled out).
        send_seq('{8'h40, 8'h03, 8'h0E, 8'hCD, 8'h11, 8'h22, 8'h33, 8'h55});
        send_seq('{8'hE0, 8'h03, 8'h0E, 8'hCD});
        repeat (10) @(negedge clock);
        clear_cap();
        send_seq('{8'h80, 8'h03, 8'h0E, 8'hCD});
        wait_pulses("draw", 4);
`ifdef CONTROLLER_DRAW_EN
        check_bytes("draw", '{8'h20, 8'h20, 8'h20, 8'h20});
`else
        check_bytes("draw", '{8'h11, 8'h22, 8'h33, 8'h55});
`endif

        check("protocol_viol", 32'(viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, internal byte-memory address width (memory depth 2^ADDR_WIDTH bytes).
REQ-002 clock  input  1  sole clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 received  input  1  one-cycle strobe: rx_byte holds a new UART byte.
REQ-005 rx_byte  input  8  received byte, valid while received=1.
REQ-006 is_transmitting  input  1  UART transmitter busy.
REQ-007 transmit  output  1  one-cycle strobe requesting UART to send tx_byte.
REQ-008 tx_byte  output  8  byte to send, valid while transmit=1.

Function
REQ-009 Command byte: field rx_byte[7:6], param rx_byte[5:0]; COMMAND_WRITE=8'h40, COMMAND_READ=8'h80, COMMAND_DRAW=8'hC0 SHALL be `define macros in the module source.
REQ-010 Field 2'b00 in IDLE SHALL be ignored (NOP), state unchanged.
REQ-011 Frame after command byte: length byte N, address high byte, address low byte; transfer count = N+1 (1..256 bytes).
REQ-012 Address = {hi,lo}[ADDR_WIDTH-1:0]; upper bits discarded; address increments per byte and wraps modulo 2^ADDR_WIDTH.
REQ-013 States: IDLE, LEN, ADDR_HI, ADDR_LO, WR_DATA, RD_FETCH, RD_SEND, RD_WAIT, DRAW_FILL.
REQ-014 IDLE/LEN/ADDR_HI/ADDR_LO/WR_DATA advance only on received=1; no timeout.
REQ-015 WRITE: after ADDR_LO, each of next N+1 received bytes written to memory at current address in the same cycle; after last byte, return to IDLE.
REQ-016 READ: after ADDR_LO, enter RD_FETCH; memory read latency is one cycle.
REQ-017 RD_SEND: when is_transmitting=0, assert transmit for exactly one cycle with tx_byte=mem[addr], then enter RD_WAIT.
REQ-018 RD_WAIT lasts exactly one cycle (UART busy-flag settling), then RD_FETCH for next byte or IDLE after N+1 bytes.
REQ-019 transmit SHALL never be high in two consecutive cycles nor while is_transmitting=1.
REQ-020 DRAW: after ADDR_LO, DRAW_FILL writes {2'b00,param} to N+1 consecutive addresses, one per cycle, then IDLE.
REQ-021 received=1 in RD_FETCH, RD_SEND, RD_WAIT or DRAW_FILL SHALL be dropped; no buffering.
REQ-022 tx_byte holds its last value when transmit=0.
REQ-023 N=8'hFF transfers 256 bytes; address wrap mid-transfer is legal.

Reset
REQ-024 reset=1 SHALL force state IDLE, transmit=0, tx_byte=8'h00, counters and address 0 at next clock edge, overriding received.
REQ-025 Reset mid-frame SHALL abort the frame; completed writes persist; memory contents are not cleared.

Configuration
REQ-026 Macro CONTROLLER_DRAW_EN defined: DRAW command implemented per REQ-020.
REQ-027 CONTROLLER_DRAW_EN undefined: field 2'b11 treated as NOP in IDLE; no DRAW_FILL state or fill logic synthesized.

Verification
REQ-028 WRITE 40,02,0E,CD,42,43,44 then READ 80,02,0E,CD -> three transmit pulses with tx_byte 42,43,44 in order.
REQ-029 WRITE 40,02,0A,10,44,45,46; READ 80,02,0A,10 with is_transmitting held 1 for 5 cycles after first pulse -> next pulse delayed until is_transmitting=0; bytes 44,45,46; transmit never high while busy.
REQ-030 WRITE 40,00,0F,FF,AA then WRITE 40,00,00,00,BB; READ 80,01,0F,FF -> tx_byte AA,BB (wrap at 12-bit boundary).
REQ-031 With CONTROLLER_DRAW_EN: DRAW E0,03,0E,CD then READ 80,03,0E,CD -> tx_byte 20,20,20,20; without macro -> original memory contents returned.
REQ-032 Reset asserted after 40,02,0E received, then READ of 0ECD -> previous contents unchanged; transmit=0, tx_byte=00 immediately after reset.
REQ-033 Bytes sent during an active READ -> ignored; READ output sequence unchanged; controller IDLE afterwards.
